// File: rtl/spi_sensor_poller.sv
// ---------------------------------------------------------------------------
// spi_sensor_poller
//
// Read-only SPI master that polls NCH serial sensors (LM07 style) over one
// shared SCK. Each sensor has its own active-low chip select and its own
// serial data line. Every frame is FRAME_BITS wide and is shifted in MSB
// first. The result is presented on DOUT/DCH together with a one-cycle
// DVALID strobe.
//
// Parameters
//   NCH        number of sensor channels (1..16)
//   FRAME_BITS bits per frame (2..32)
//   CLKDIV     SYSCLK cycles per SCK half-period (>=1)
//   GAP_CYCLES SYSCLK cycles spent in GAP between frames (>=1)
//   CHW        channel index width (>= clog2(NCH), minimum 1)
//
// Ports
//   SYSCLK  in   system clock, rising edge
//   RST     in   asynchronous active-high reset
//   EN      in   continuous mode: keep rescanning while high
//   START   in   single-shot: one pulse starts one scan of all channels
//   BUSY    out  high from the first SETUP cycle until the return to IDLE
//   CS      out  per-channel chip select, active-low, at most one low
//   SCK     out  shared serial clock, idles low
//   SIO     in   per-channel serial data from the sensors
//   DOUT    out  last completed frame, MSB = first bit received
//   DCH     out  channel index of DOUT
//   DVALID  out  one-cycle strobe, DOUT/DCH updated this cycle
//
// Optional feature (macro SPI_POLL_LASTVAL_EN)
//   RADDR   in   read address into the per-channel last-value bank
//   RDATA   out  bank[RADDR], registered, one cycle latency, 0 if RADDR>=NCH
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module spi_sensor_poller #(
  parameter int NCH        = 4,
  parameter int FRAME_BITS = 16,
  parameter int CLKDIV     = 2,
  parameter int GAP_CYCLES = 4,
  parameter int CHW        = 2
) (
  input  logic                  SYSCLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  START,
  output logic                  BUSY,
  output logic [NCH-1:0]        CS,
  output logic                  SCK,
  input  logic [NCH-1:0]        SIO,
  output logic [FRAME_BITS-1:0] DOUT,
  output logic [CHW-1:0]        DCH,
  output logic                  DVALID
`ifdef SPI_POLL_LASTVAL_EN
  ,
  input  logic [CHW-1:0]        RADDR,
  output logic [FRAME_BITS-1:0] RDATA
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int BW = $clog2(FRAME_BITS);

  localparam logic [DW-1:0]  DIV_LAST = DW'(CLKDIV - 1);
  localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(FRAME_BITS - 1);
  localparam logic [CHW-1:0] CH_LAST  = CHW'(NCH - 1);

  logic [2:0]            state_q, state_d;
  logic [CHW-1:0]        ch_q, ch_d;
  logic [DW-1:0]         div_q, div_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [FRAME_BITS-1:0] dout_q, dout_d;
  logic [CHW-1:0]        dch_q, dch_d;
  logic                  dvalid_q, dvalid_d;
  logic                  busy_q, busy_d;
  logic [NCH-1:0]        cs_q, cs_d;
  logic                  sck_q, sck_d;

  logic                  sio_bit;
  logic                  div_end;
  logic                  frame_d;

  // Select the data line of the active channel. A compare loop keeps the
  // mux free of out-of-range indexing when NCH is not a power of two.
  always_comb begin
    sio_bit = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_q == CHW'(i)) sio_bit = SIO[i];
    end
  end

  // Next-state logic. Every registered output is computed from the next
  // state, so outputs change on the same edge as the state they belong to.
  // SIO is shifted in on the edge that enters HIGH, i.e. the edge that
  // drives SCK high.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    div_d    = div_q;
    bit_d    = bit_q;
    gap_d    = gap_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    dch_d    = dch_q;
    div_end  = (div_q == DIV_LAST);

    case (state_q)
      S_IDLE: begin
        if (EN || START) begin
          state_d = S_SETUP;
          ch_d    = '0;
          div_d   = '0;
          bit_d   = '0;
        end
      end

      S_SETUP: begin
        if (div_end) begin
          state_d = S_HIGH;
          div_d   = '0;
          shift_d = {shift_q[FRAME_BITS-2:0], sio_bit};
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_HIGH: begin
        if (div_end) begin
          state_d = S_LOW;
          div_d   = '0;
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_LOW: begin
        if (div_end) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = S_DONE;
            dout_d  = shift_q;
            dch_d   = ch_q;
          end else begin
            state_d = S_HIGH;
            bit_d   = bit_q + 1'b1;
            shift_d = {shift_q[FRAME_BITS-2:0], sio_bit};
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_GAP;
        gap_d   = '0;
      end

      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          div_d = '0;
          bit_d = '0;
          // EN is only consulted after the last channel, so a scan that
          // has started always runs through channel NCH-1.
          if (ch_q != CH_LAST) begin
            ch_d    = ch_q + 1'b1;
            state_d = S_SETUP;
          end else if (EN) begin
            ch_d    = '0;
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    frame_d  = (state_d == S_SETUP) || (state_d == S_HIGH) || (state_d == S_LOW);
    sck_d    = (state_d == S_HIGH);
    busy_d   = (state_d != S_IDLE);
    dvalid_d = (state_d == S_DONE);
    cs_d     = '1;
    for (int i = 0; i < NCH; i++) begin
      if (frame_d && (ch_d == CHW'(i))) cs_d[i] = 1'b0;
    end
  end

  // State and output registers. Reset aborts any frame in flight.
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      gap_q    <= '0;
      shift_q  <= '0;
      dout_q   <= '0;
      dch_q    <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      cs_q     <= '1;
      sck_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      gap_q    <= gap_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      dch_q    <= dch_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      cs_q     <= cs_d;
      sck_q    <= sck_d;
    end
  end

  assign BUSY   = busy_q;
  assign CS     = cs_q;
  assign SCK    = sck_q;
  assign DOUT   = dout_q;
  assign DCH    = dch_q;
  assign DVALID = dvalid_q;

`ifdef SPI_POLL_LASTVAL_EN
  logic [FRAME_BITS-1:0] bank_q [NCH];
  logic [FRAME_BITS-1:0] bank_d [NCH];
  logic [FRAME_BITS-1:0] rdata_q, rdata_d;

  // The bank is written from the DVALID cycle. The read port samples the
  // bank before that write lands, so a same-cycle read returns the old
  // value. Addresses with no matching entry read as zero.
  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < NCH; i++) begin
      bank_d[i] = bank_q[i];
      if (dvalid_q && (dch_q == CHW'(i))) bank_d[i] = dout_q;
      if (RADDR == CHW'(i)) rdata_d = bank_q[i];
    end
  end

  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NCH; i++) bank_q[i] <= '0;
      rdata_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) bank_q[i] <= bank_d[i];
      rdata_q <= rdata_d;
    end
  end

  assign RDATA = rdata_q;
`endif

endmodule

// File: tb/tb_spi_sensor_poller.sv
// ---------------------------------------------------------------------------
// tb_spi_sensor_poller
//
// Bench for spi_sensor_poller. Three instances:
//   dut_a  NCH=4, FRAME_BITS=16, CLKDIV=2, CHW=3 (main scan tests)
//   dut_b  NCH=1, FRAME_BITS=8,  CLKDIV=1        (fast divider corner)
//   dut_c  NCH=1, FRAME_BITS=32, CLKDIV=2        (wide frame corner)
// Each sensor is modelled as a shift register that presents its MSB when CS
// falls and advances on every SCK falling edge. Expected frames are queued
// when a scan is launched; per-instance monitors pop and compare on DVALID.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_spi_sensor_poller;

  localparam int A_NCH = 4, A_FB = 16, A_DIV = 2, A_GAP = 4, A_CHW = 3;
  localparam int B_FB  = 8, B_DIV = 1, B_GAP = 4;
  localparam int C_FB  = 32, C_DIV = 2, C_GAP = 4;

  typedef struct packed {
    logic [3:0]  ch;
    logic [31:0] data;
  } exp_t;

  logic SYSCLK = 1'b1;
  logic rst    = 1'b1;

  logic              en_a = 1'b0, start_a = 1'b0;
  logic              busy_a, sck_a, dvalid_a;
  logic [A_NCH-1:0]  cs_a, sio_a;
  logic [A_FB-1:0]   dout_a;
  logic [A_CHW-1:0]  dch_a;

  logic              start_b = 1'b0;
  logic              busy_b, sck_b, dvalid_b;
  logic [0:0]        cs_b, sio_b, dch_b;
  logic [B_FB-1:0]   dout_b;

  logic              start_c = 1'b0;
  logic              busy_c, sck_c, dvalid_c;
  logic [0:0]        cs_c, sio_c, dch_c;
  logic [C_FB-1:0]   dout_c;

`ifdef SPI_POLL_LASTVAL_EN
  logic [A_CHW-1:0]  raddr_a = '0;
  logic [A_FB-1:0]   rdata_a;
  logic [0:0]        raddr_b = '0, raddr_c = '0;
  logic [B_FB-1:0]   rdata_b;
  logic [C_FB-1:0]   rdata_c;
`endif

  logic [15:0] sens_a [A_NCH];
  logic [7:0]  sens_b;
  logic [31:0] sens_c;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];

  int tests = 0;
  int fails = 0;

  always #5 SYSCLK = ~SYSCLK;

  spi_sensor_poller #(.NCH(A_NCH), .FRAME_BITS(A_FB), .CLKDIV(A_DIV),
                      .GAP_CYCLES(A_GAP), .CHW(A_CHW)) dut_a (
    .SYSCLK(SYSCLK), .RST(rst), .EN(en_a), .START(start_a), .BUSY(busy_a),
    .CS(cs_a), .SCK(sck_a), .SIO(sio_a), .DOUT(dout_a), .DCH(dch_a),
    .DVALID(dvalid_a)
`ifdef SPI_POLL_LASTVAL_EN
    , .RADDR(raddr_a), .RDATA(rdata_a)
`endif
  );

  spi_sensor_poller #(.NCH(1), .FRAME_BITS(B_FB), .CLKDIV(B_DIV),
                      .GAP_CYCLES(B_GAP), .CHW(1)) dut_b (
    .SYSCLK(SYSCLK), .RST(rst), .EN(1'b0), .START(start_b), .BUSY(busy_b),
    .CS(cs_b), .SCK(sck_b), .SIO(sio_b), .DOUT(dout_b), .DCH(dch_b),
    .DVALID(dvalid_b)
`ifdef SPI_POLL_LASTVAL_EN
    , .RADDR(raddr_b), .RDATA(rdata_b)
`endif
  );

  spi_sensor_poller #(.NCH(1), .FRAME_BITS(C_FB), .CLKDIV(C_DIV),
                      .GAP_CYCLES(C_GAP), .CHW(1)) dut_c (
    .SYSCLK(SYSCLK), .RST(rst), .EN(1'b0), .START(start_c), .BUSY(busy_c),
    .CS(cs_c), .SCK(sck_c), .SIO(sio_c), .DOUT(dout_c), .DCH(dch_c),
    .DVALID(dvalid_c)
`ifdef SPI_POLL_LASTVAL_EN
    , .RADDR(raddr_c), .RDATA(rdata_c)
`endif
  );

  // Sensor models: the bit index returns to the MSB whenever CS is high and
  // steps down on each SCK falling edge while selected.
  for (genvar g = 0; g < A_NCH; g++) begin : g_sens_a
    int idx = A_FB - 1;
    always @(negedge sck_a or posedge cs_a[g]) begin
      if (cs_a[g]) idx = A_FB - 1;
      else         idx = idx - 1;
    end
    assign sio_a[g] = (idx >= 0) ? sens_a[g][idx] : 1'b0;
  end

  int idx_b = B_FB - 1;
  always @(negedge sck_b or posedge cs_b[0]) begin
    if (cs_b[0]) idx_b = B_FB - 1;
    else         idx_b = idx_b - 1;
  end
  assign sio_b[0] = (idx_b >= 0) ? sens_b[idx_b] : 1'b0;

  int idx_c = C_FB - 1;
  always @(negedge sck_c or posedge cs_c[0]) begin
    if (cs_c[0]) idx_c = C_FB - 1;
    else         idx_c = idx_c - 1;
  end
  assign sio_c[0] = (idx_c >= 0) ? sens_c[idx_c] : 1'b0;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic pulseStart(input int sel);
    @(negedge SYSCLK);
    case (sel)
      0: start_a = 1'b1;
      1: start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    @(negedge SYSCLK);
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  // Queue the frames one scan should produce from the current sensor
  // contents, then launch the scan with a START pulse.
  task automatic applyStimulus(input int sel);
    exp_t e;
    case (sel)
      0: for (int i = 0; i < A_NCH; i++) begin
           e.ch = 4'(i); e.data = 32'(sens_a[i]); exp_a.push_back(e);
         end
      1: begin e.ch = 4'd0; e.data = 32'(sens_b); exp_b.push_back(e); end
      default: begin e.ch = 4'd0; e.data = sens_c; exp_c.push_back(e); end
    endcase
    pulseStart(sel);
  endtask

  task automatic waitIdle(input int sel, input int maxCycles);
    int   n;
    logic b;
    n = 0;
    b = 1'b1;
    while (b && n < maxCycles) begin
      @(negedge SYSCLK);
      n++;
      b = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
    end
    checkOutput("idle_reached", 32'(b), 32'd0);
  endtask

  // Monitor for dut_a: frame timing, CS exclusivity, gap length, BUSY drop
  // and the scoreboard.
  int cyc = 0, low_cnt = 0, rise_cnt = 0, gap_cnt = 0, last_dv = 0, dv_count_a = 0;
  bit prev_low = 0, prev_sck = 0, prev_busy = 0, after_frame = 0;
  always @(negedge SYSCLK) begin
    exp_t e;
    cyc++;
    if (rst) begin
      low_cnt = 0; rise_cnt = 0; gap_cnt = 0;
      prev_low = 0; prev_sck = 0; prev_busy = 0; after_frame = 0;
    end else begin
      checkOutput("a_cs_onehot", 32'($countones(~cs_a) <= 1), 32'd1);
      if (cs_a != '1) begin
        if (!prev_low && after_frame) checkOutput("a_gap_len", 32'(gap_cnt), 32'(A_GAP + 1));
        gap_cnt = 0;
        low_cnt++;
        if (sck_a && !prev_sck) rise_cnt++;
      end else begin
        checkOutput("a_sck_idle", 32'(sck_a), 32'd0);
        if (prev_low) begin
          checkOutput("a_cs_low_len", 32'(low_cnt), 32'(A_DIV * (1 + 2 * A_FB)));
          checkOutput("a_sck_rises", 32'(rise_cnt), 32'(A_FB));
          low_cnt = 0; rise_cnt = 0; after_frame = 1;
        end
        if (busy_a) gap_cnt++;
        else begin gap_cnt = 0; after_frame = 0; end
      end
      if (dvalid_a) begin
        dv_count_a++;
        last_dv = cyc;
        checkOutput("a_frame_expected", 32'(exp_a.size() > 0), 32'd1);
        if (exp_a.size() > 0) begin
          e = exp_a.pop_front();
          checkOutput("a_dch", 32'(dch_a), 32'(e.ch));
          checkOutput("a_dout", 32'(dout_a), e.data);
        end
      end
      if (prev_busy && !busy_a) checkOutput("a_busy_drop", 32'(cyc - last_dv), 32'(A_GAP + 1));
      prev_low  = (cs_a != '1);
      prev_sck  = sck_a;
      prev_busy = busy_a;
    end
  end

  // Monitor for dut_b: with CLKDIV=1 SCK must toggle on every cycle of
  // the frame after the single SETUP cycle.
  int low_b = 0, rise_b = 0;
  bit lowp_b = 0, sckp_b = 0;
  always @(negedge SYSCLK) begin
    exp_t e;
    if (rst) begin
      low_b = 0; rise_b = 0; lowp_b = 0; sckp_b = 0;
    end else begin
      if (!cs_b[0]) begin
        low_b++;
        if (sck_b && !sckp_b) rise_b++;
        if (low_b > 1) checkOutput("b_sck_toggle", 32'(sck_b), 32'(!sckp_b));
      end else if (lowp_b) begin
        checkOutput("b_cs_low_len", 32'(low_b), 32'(B_DIV * (1 + 2 * B_FB)));
        checkOutput("b_sck_rises", 32'(rise_b), 32'(B_FB));
        low_b = 0; rise_b = 0;
      end
      if (dvalid_b) begin
        checkOutput("b_frame_expected", 32'(exp_b.size() > 0), 32'd1);
        if (exp_b.size() > 0) begin
          e = exp_b.pop_front();
          checkOutput("b_dch", 32'(dch_b), 32'(e.ch));
          checkOutput("b_dout", 32'(dout_b), e.data);
        end
      end
      lowp_b = !cs_b[0];
      sckp_b = sck_b;
    end
  end

  // Monitor for dut_c: wide frame.
  int low_c = 0, rise_c = 0;
  bit lowp_c = 0, sckp_c = 0;
  always @(negedge SYSCLK) begin
    exp_t e;
    if (rst) begin
      low_c = 0; rise_c = 0; lowp_c = 0; sckp_c = 0;
    end else begin
      if (!cs_c[0]) begin
        low_c++;
        if (sck_c && !sckp_c) rise_c++;
      end else if (lowp_c) begin
        checkOutput("c_cs_low_len", 32'(low_c), 32'(C_DIV * (1 + 2 * C_FB)));
        checkOutput("c_sck_rises", 32'(rise_c), 32'(C_FB));
        low_c = 0; rise_c = 0;
      end
      if (dvalid_c) begin
        checkOutput("c_frame_expected", 32'(exp_c.size() > 0), 32'd1);
        if (exp_c.size() > 0) begin
          e = exp_c.pop_front();
          checkOutput("c_dch", 32'(dch_c), 32'(e.ch));
          checkOutput("c_dout", dout_c, e.data);
        end
      end
      lowp_c = !cs_c[0];
      sckp_c = sck_c;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_t e;
    int   base;
    int   n;
    int   rises;
    bit   reached;
    bit   sp;

    sens_a[0] = 16'hA60A; sens_a[1] = 16'h5A5A;
    sens_a[2] = 16'h0001; sens_a[3] = 16'hFFFF;
    sens_b = 8'hA6;
    sens_c = 32'h8000_0001;

    // Reset values while RST is held.
    #12;
    checkOutput("rst_cs",     32'(cs_a),     32'hF);
    checkOutput("rst_sck",    32'(sck_a),    32'd0);
    checkOutput("rst_busy",   32'(busy_a),   32'd0);
    checkOutput("rst_dout",   32'(dout_a),   32'd0);
    checkOutput("rst_dch",    32'(dch_a),    32'd0);
    checkOutput("rst_dvalid", 32'(dvalid_a), 32'd0);
    #3 rst = 1'b0;

    // Basic frame on channel 0, then the rest of the single-shot scan.
    applyStimulus(0);
    waitIdle(0, 2000);

    // Round-robin with distinct channel values.
    sens_a[0] = 16'h1111; sens_a[1] = 16'h2222;
    sens_a[2] = 16'h3333; sens_a[3] = 16'h4444;
    applyStimulus(0);
    // START while busy must be ignored: a second pulse mid-scan queues nothing.
    repeat (100) @(negedge SYSCLK);
    pulseStart(0);
    waitIdle(0, 2000);
    repeat (20) @(negedge SYSCLK);
    checkOutput("a_no_queued_start", 32'(busy_a), 32'd0);

`ifdef SPI_POLL_LASTVAL_EN
    begin
      logic [A_CHW-1:0] addrs [5];
      logic [15:0]      exps  [5];
      addrs[0] = 3'd0; exps[0] = 16'h1111;
      addrs[1] = 3'd1; exps[1] = 16'h2222;
      addrs[2] = 3'd2; exps[2] = 16'h3333;
      addrs[3] = 3'd3; exps[3] = 16'h4444;
      addrs[4] = 3'd5; exps[4] = 16'h0000;
      for (int i = 0; i < 5; i++) begin
        @(negedge SYSCLK);
        raddr_a = addrs[i];
        @(negedge SYSCLK);
        checkOutput("a_rdata", 32'(rdata_a), 32'(exps[i]));
      end
    end
`endif

    // Continuous mode: two full scans, then EN drops during channel 1 of
    // the third scan, which still completes through channel 3.
    sens_a[0] = 16'h0F0F; sens_a[1] = 16'hF0F0;
    sens_a[2] = 16'h8001; sens_a[3] = 16'h7FFE;
    for (int s = 0; s < 3; s++) begin
      for (int i = 0; i < A_NCH; i++) begin
        e.ch = 4'(i); e.data = 32'(sens_a[i]); exp_a.push_back(e);
      end
    end
    base = dv_count_a;
    @(negedge SYSCLK);
    en_a = 1'b1;
    reached = 1'b0;
    n = 0;
    while (!reached && n < 3000) begin
      @(negedge SYSCLK);
      n++;
      if (dv_count_a >= base + 9 && !cs_a[1]) reached = 1'b1;
    end
    checkOutput("a_en_drop_point", 32'(reached), 32'd1);
    en_a = 1'b0;
    waitIdle(0, 2000);
    repeat (200) @(negedge SYSCLK);
    checkOutput("a_cont_frames", 32'(dv_count_a - base), 32'd12);
    checkOutput("a_cont_drained", 32'(exp_a.size()), 32'd0);

    // Reset after the fifth SCK rise: frame aborted, no DVALID.
    sens_a[0] = 16'h1111; sens_a[1] = 16'h2222;
    sens_a[2] = 16'h3333; sens_a[3] = 16'h4444;
    pulseStart(0);
    rises = 0;
    sp = 1'b0;
    n = 0;
    while (rises < 5 && n < 1000) begin
      @(negedge SYSCLK);
      n++;
      if (sck_a && !sp) rises++;
      sp = sck_a;
    end
    checkOutput("a_five_rises", 32'(rises), 32'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_cs",     32'(cs_a),     32'hF);
    checkOutput("mid_rst_sck",    32'(sck_a),    32'd0);
    checkOutput("mid_rst_dvalid", 32'(dvalid_a), 32'd0);
    checkOutput("mid_rst_dout",   32'(dout_a),   32'd0);
    checkOutput("mid_rst_busy",   32'(busy_a),   32'd0);
    repeat (2) @(negedge SYSCLK);
    rst = 1'b0;
    applyStimulus(0);
    waitIdle(0, 2000);

    // Divider and width corners.
    applyStimulus(1);
    waitIdle(1, 500);
    applyStimulus(2);
    waitIdle(2, 1000);

    repeat (20) @(negedge SYSCLK);
    checkOutput("a_sb_drained", 32'(exp_a.size()), 32'd0);
    checkOutput("b_sb_drained", 32'(exp_b.size()), 32'd0);
    checkOutput("c_sb_drained", 32'(exp_c.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
